// File: rtl/seg_mode_scanner.sv
// Debounced mode-select pushbutton with optional timed auto-advance, and a
// registered 4-digit multiplexed seven-segment driver for the display datapath.
module seg_mode_scanner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SCAN_CYCLES     = 100_000,
  parameter int AUTO_CYCLES     = 200_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_next,
  input  logic       auto_en,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] C,
  input  logic [3:0] D,
  output logic [1:0] mode_sel,
  output logic       mode_changed,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  // state  | meaning
  // ST_ID  | digits shown as-is
  // ST_HEX | hex view
  // ST_X2  | doubled operands
  // ST_SUM | operand sum
  typedef enum logic [1:0] {
    ST_ID  = 2'b00,
    ST_HEX = 2'b01,
    ST_X2  = 2'b10,
    ST_SUM = 2'b11
  } mode_t;

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int AUTO_W = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;

  logic              btn_s1, btn_s2;
  logic [DB_W-1:0]   db_cnt;
  logic              btn_acc, btn_acc_q;
  logic              next_pulse;
  logic [AUTO_W-1:0] auto_cnt;
  logic              auto_req;
  logic              advance;
  mode_t             state, state_nxt;
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        dig_idx;
  logic [3:0]        dig_val;
  logic [3:0]        an_nxt;
  logic [6:0]        seg_nxt;
  logic              dp_nxt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      btn_s1    <= 1'b0;
      btn_s2    <= 1'b0;
      db_cnt    <= '0;
      btn_acc   <= 1'b0;
      btn_acc_q <= 1'b0;
    end else begin
      btn_s1    <= btn_next;
      btn_s2    <= btn_s1;
      btn_acc_q <= btn_acc;
      if (btn_s2 == btn_acc) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_cnt  <= '0;
        btn_acc <= ~btn_acc;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Press edge only; the release edge is deliberately ignored.
  assign next_pulse = btn_acc & ~btn_acc_q;
  assign auto_req   = auto_en && (auto_cnt == AUTO_W'(AUTO_CYCLES - 1));
  assign advance    = next_pulse | auto_req;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      auto_cnt <= '0;
    end else if (!auto_en || next_pulse || auto_req) begin
      auto_cnt <= '0;
    end else begin
      auto_cnt <= auto_cnt + AUTO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_ID;
      mode_changed <= 1'b0;
    end else begin
      state        <= state_nxt;
      mode_changed <= advance;
    end
  end

  always_comb begin
    state_nxt = state;
    if (advance) begin
      case (state)
        ST_ID:   state_nxt = ST_HEX;
        ST_HEX:  state_nxt = ST_X2;
        ST_X2:   state_nxt = ST_SUM;
        default: state_nxt = ST_ID;
      endcase
    end
  end

  assign mode_sel = state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scan_cnt <= '0;
      dig_idx  <= 2'd0;
    end else if (scan_cnt == SCAN_W'(SCAN_CYCLES - 1)) begin
      scan_cnt <= '0;
      dig_idx  <= dig_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  always_comb begin
    dig_val = D;
    case (dig_idx)
      2'd0:    dig_val = D;
      2'd1:    dig_val = C;
      2'd2:    dig_val = B;
      default: dig_val = A;
    endcase
  end

  always_comb begin
    seg_nxt = 7'b1111111;
    case (dig_val)
      4'h0: seg_nxt = 7'b1000000;
      4'h1: seg_nxt = 7'b1111001;
      4'h2: seg_nxt = 7'b0100100;
      4'h3: seg_nxt = 7'b0110000;
      4'h4: seg_nxt = 7'b0011001;
      4'h5: seg_nxt = 7'b0010010;
      4'h6: seg_nxt = 7'b0000010;
      4'h7: seg_nxt = 7'b1111000;
      4'h8: seg_nxt = 7'b0000000;
      4'h9: seg_nxt = 7'b0010000;
      4'hA: seg_nxt = 7'b0001000;
      4'hB: seg_nxt = 7'b0000011;
      4'hC: seg_nxt = 7'b1000110;
      4'hD: seg_nxt = 7'b0100001;
      4'hE: seg_nxt = 7'b0000110;
      default: seg_nxt = 7'b0001110;
    endcase
  end

  // dp marks the operand/result boundary in the two arithmetic modes.
  assign an_nxt = ~(4'b0001 << dig_idx);
  assign dp_nxt = ~((dig_idx == 2'd2) & mode_sel[1]);

  // an, seg and dp load together so a digit never shows a neighbour's value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg_mode_scanner.sv
// Directed bench for seg_mode_scanner with small timing parameters.
module tb_seg_mode_scanner;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_next;
  logic       auto_en;
  logic [3:0] a_v, b_v, c_v, d_v;
  logic [1:0] mode_sel;
  logic       mode_changed;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_assert = 0;
  int n_fail   = 0;
  int mc_total = 0;

  seg_mode_scanner #(
    .DEBOUNCE_CYCLES(4),
    .SCAN_CYCLES(3),
    .AUTO_CYCLES(20)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .btn_next(btn_next),
    .auto_en(auto_en),
    .A(a_v),
    .B(b_v),
    .C(c_v),
    .D(d_v),
    .mode_sel(mode_sel),
    .mode_changed(mode_changed),
    .an(an),
    .seg(seg),
    .dp(dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // One clock; leaves the caller at the falling edge with outputs settled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (mode_changed === 1'b1) mc_total++;
  endtask

  task automatic press(input int high_clks, input int low_clks);
    btn_next = 1'b1;
    for (int i = 0; i < high_clks; i++) step();
    btn_next = 1'b0;
    for (int i = 0; i < low_clks; i++) step();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step();
    n_assert++; if (mode_sel !== 2'b00) begin n_fail++; $display("FAIL reset_mode: got %b want 00", mode_sel); end
    n_assert++; if (mode_changed !== 1'b0) begin n_fail++; $display("FAIL reset_mc: got %b want 0", mode_changed); end
    n_assert++; if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an: got %b want 1111", an); end
    n_assert++; if (seg !== 7'b1111111) begin n_fail++; $display("FAIL reset_seg: got %b want 1111111", seg); end
    n_assert++; if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b want 1", dp); end
  endtask

  task automatic test_scan();
    logic [3:0] an_exp [4];
    logic [6:0] seg_exp [4];
    an_exp[0] = 4'b1110; seg_exp[0] = 7'b0000010;
    an_exp[1] = 4'b1101; seg_exp[1] = 7'b0010000;
    an_exp[2] = 4'b1011; seg_exp[2] = 7'b0011001;
    an_exp[3] = 4'b0111; seg_exp[3] = 7'b0000010;
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      n_assert++; if (an !== an_exp[i/3]) begin n_fail++; $display("FAIL scan_an[%0d]: got %b want %b", i, an, an_exp[i/3]); end
      n_assert++; if (seg !== seg_exp[i/3]) begin n_fail++; $display("FAIL scan_seg[%0d]: got %b want %b", i, seg, seg_exp[i/3]); end
      n_assert++; if (dp !== 1'b1) begin n_fail++; $display("FAIL scan_dp[%0d]: got %b want 1", i, dp); end
    end
  endtask

  task automatic test_hex_encoding();
    logic [3:0] v;
    for (int r = 0; r < 4; r++) begin
      a_v = 4'(4*r + 3); b_v = 4'(4*r + 2); c_v = 4'(4*r + 1); d_v = 4'(4*r);
      for (int i = 0; i < 12; i++) begin
        step();
        v = 4'h0;
        case (an)
          4'b1110: v = d_v;
          4'b1101: v = c_v;
          4'b1011: v = b_v;
          4'b0111: v = a_v;
          default: begin
            n_assert++; n_fail++;
            $display("FAIL hex_an: got %b want one low bit", an);
          end
        endcase
        n_assert++;
        if (seg !== hex_seg(v)) begin n_fail++; $display("FAIL hex_seg[%0h]: got %b want %b", v, seg, hex_seg(v)); end
      end
    end
  endtask

  task automatic test_glitch_then_press();
    int mc0, first;
    mc0 = mc_total; first = 0;
    btn_next = 1'b1; step(); step();
    btn_next = 1'b0; step(); step(); step();
    btn_next = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (mode_changed === 1'b1 && first == 0) first = k;
    end
    btn_next = 1'b0;
    for (int k = 0; k < 12; k++) step();
    n_assert++; if (mc_total - mc0 != 1) begin n_fail++; $display("FAIL glitch_pulses: got %0d want 1", mc_total - mc0); end
    n_assert++; if (first != 7) begin n_fail++; $display("FAIL press_latency: got %0d want 7", first); end
    n_assert++; if (mode_sel !== 2'b01) begin n_fail++; $display("FAIL glitch_mode: got %b want 01", mode_sel); end
  endtask

  task automatic test_four_presses();
    logic [1:0] prev_mode, exp_mode;
    logic       dp_exp;
    int mc0;
    prev_mode = mode_sel;
    exp_mode  = mode_sel;
    for (int p = 0; p < 4; p++) begin
      mc0 = mc_total;
      exp_mode = exp_mode + 2'd1;
      for (int c = 0; c < 20; c++) begin
        btn_next = (c < 8);
        step();
        n_assert++; if ($countones(~an) != 1) begin n_fail++; $display("FAIL onehot_an: got %b want one low bit", an); end
        dp_exp = !((an == 4'b1011) && prev_mode[1]);
        n_assert++; if (dp !== dp_exp) begin n_fail++; $display("FAIL dp: got %b want %b (an %b mode %b)", dp, dp_exp, an, prev_mode); end
        prev_mode = mode_sel;
      end
      n_assert++; if (mc_total - mc0 != 1) begin n_fail++; $display("FAIL press_pulses[%0d]: got %0d want 1", p, mc_total - mc0); end
      n_assert++; if (mode_sel !== exp_mode) begin n_fail++; $display("FAIL press_mode[%0d]: got %b want %b", p, mode_sel, exp_mode); end
    end
  endtask

  task automatic test_auto_and_coincidence();
    int pulse_at [8];
    int np;
    logic [1:0] m0;
    np = 0; m0 = mode_sel;
    auto_en = 1'b1;
    for (int s = 1; s <= 80; s++) begin
      btn_next = (s >= 54 && s < 64);
      step();
      if (mode_changed === 1'b1) begin
        if (np < 8) pulse_at[np] = s;
        np++;
      end
    end
    auto_en = 1'b0; btn_next = 1'b0;
    n_assert++; if (np != 4) begin n_fail++; $display("FAIL auto_count: got %0d want 4", np); end
    for (int i = 0; i < 4; i++) begin
      n_assert++;
      if (i < np && pulse_at[i] != 20*(i+1)) begin
        n_fail++; $display("FAIL auto_at[%0d]: got %0d want %0d", i, pulse_at[i], 20*(i+1));
      end
    end
    n_assert++; if (mode_sel !== m0) begin n_fail++; $display("FAIL auto_mode: got %b want %b", mode_sel, m0); end
    for (int i = 0; i < 10; i++) step();
    n_assert++; if (mode_sel !== m0) begin n_fail++; $display("FAIL auto_off_hold: got %b want %b", mode_sel, m0); end
  endtask

  task automatic test_reset_mode11();
    bit found;
    found = 1'b0;
    while (mode_sel !== 2'b11 && !found) begin
      press(8, 12);
      if (mc_total > 100) found = 1'b1;
    end
    found = 1'b0;
    n_assert++; if (mode_sel !== 2'b11) begin n_fail++; $display("FAIL r11_mode: got %b want 11", mode_sel); end
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (an == 4'b1011) found = 1'b1;
    end
    n_assert++; if (!found) begin n_fail++; $display("FAIL r11_wait_idx2: got timeout want an=1011"); end
    n_assert++; if (dp !== 1'b0) begin n_fail++; $display("FAIL r11_dp_pre: got %b want 0", dp); end
    reset_n = 1'b0;
    step();
    n_assert++; if (mode_sel !== 2'b00) begin n_fail++; $display("FAIL r11_mode_rst: got %b want 00", mode_sel); end
    n_assert++; if (an !== 4'b1111) begin n_fail++; $display("FAIL r11_an: got %b want 1111", an); end
    n_assert++; if (seg !== 7'b1111111) begin n_fail++; $display("FAIL r11_seg: got %b want 1111111", seg); end
    n_assert++; if (dp !== 1'b1) begin n_fail++; $display("FAIL r11_dp: got %b want 1", dp); end
    n_assert++; if (mode_changed !== 1'b0) begin n_fail++; $display("FAIL r11_mc: got %b want 0", mode_changed); end
    reset_n = 1'b1;
    step();
    n_assert++; if (an !== 4'b1110) begin n_fail++; $display("FAIL release_an: got %b want 1110", an); end
    n_assert++; if (seg !== hex_seg(d_v)) begin n_fail++; $display("FAIL release_seg: got %b want %b", seg, hex_seg(d_v)); end
  endtask

  task automatic test_reset_mid_debounce();
    int mc0, first;
    mc0 = mc_total; first = 0;
    btn_next = 1'b1;
    for (int i = 0; i < 4; i++) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    mc0 = mc_total;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (mode_changed === 1'b1 && first == 0) first = k;
    end
    btn_next = 1'b0;
    for (int k = 0; k < 12; k++) step();
    n_assert++; if (first != 7) begin n_fail++; $display("FAIL rst_debounce_latency: got %0d want 7", first); end
    n_assert++; if (mc_total - mc0 != 1) begin n_fail++; $display("FAIL rst_debounce_pulses: got %0d want 1", mc_total - mc0); end
    n_assert++; if (mode_sel !== 2'b01) begin n_fail++; $display("FAIL rst_debounce_mode: got %b want 01", mode_sel); end
  endtask

  task automatic test_held_button();
    int mc0;
    mc0 = mc_total;
    press(50, 20);
    n_assert++; if (mc_total - mc0 != 1) begin n_fail++; $display("FAIL held_pulses: got %0d want 1", mc_total - mc0); end
    n_assert++; if (mode_sel !== 2'b10) begin n_fail++; $display("FAIL held_mode: got %b want 10", mode_sel); end
  endtask

  initial begin
    reset_n = 1'b0; btn_next = 1'b0; auto_en = 1'b0;
    a_v = 4'd6; b_v = 4'd4; c_v = 4'd9; d_v = 4'd6;
    test_reset();
    test_scan();
    test_hex_encoding();
    test_glitch_then_press();
    test_four_presses();
    test_auto_and_coincidence();
    test_reset_mode11();
    test_reset_mid_debounce();
    test_held_button();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_mode_scanner.md
SEG_MODE_SCANNER -- requirements
Module: seg_mode_scanner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, meaning clocks a raw button level must hold before it is accepted (10 ms at 100 MHz).
REQ-002 SHALL have parameter SCAN_CYCLES, default 100_000, meaning clocks each digit stays enabled (1 ms).
REQ-003 SHALL have parameter AUTO_CYCLES, default 200_000_000, meaning clocks between automatic mode advances (2 s).
REQ-004 SHALL have port clk  input  1  system clock, the only clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port btn_next  input  1  raw asynchronous pushbutton, active-high.
REQ-007 SHALL have port auto_en  input  1  level; 1 enables timed mode cycling.
REQ-008 SHALL have ports A, B, C, D  input  4 each  digit values from the display datapath, A leftmost.
REQ-009 SHALL have port mode_sel  output  2  mode driven to the datapath.
REQ-010 SHALL have port mode_changed  output  1  one-clock pulse on every mode advance.
REQ-011 SHALL have port an  output  4  digit enables, active-low, an[0] rightmost.
REQ-012 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-013 SHALL have port dp  output  1  decimal point, active-low.

Function
REQ-014 SHALL pass btn_next through a two-flop synchronizer before any other use.
REQ-015 Debounce: SHALL count consecutive clocks where the synchronized level differs from the accepted level, SHALL clear the count on any clock where they match, and SHALL toggle the accepted level when the count reaches DEBOUNCE_CYCLES-1.
REQ-016 SHALL generate a one-clock next_pulse on each 0->1 transition of the accepted level only. Release (1->0) generates nothing.
REQ-017 Mode FSM states: ID=00, HEX=01, X2=10, SUM=11. mode_sel SHALL equal the registered state.
REQ-018 Each advance SHALL step ID->HEX->X2->SUM->ID (wrap SUM->ID).
REQ-019 Auto counter SHALL run only while auto_en=1. It SHALL hold at 0 while auto_en=0, and SHALL request an advance and return to 0 when it reaches AUTO_CYCLES-1.
REQ-020 next_pulse SHALL clear the auto counter. If next_pulse and an auto request coincide, the FSM SHALL advance exactly one state.
REQ-021 mode_changed SHALL be 1 in the clock in which mode_sel takes its new value, and 0 otherwise.
REQ-022 Scan counter SHALL count 0..SCAN_CYCLES-1 and wrap. On wrap, the 2-bit digit index SHALL increment 0->1->2->3->0.
REQ-023 Index 0 SHALL drive an=1110 showing D, index 1 an=1101 showing C, index 2 an=1011 showing B, and index 3 an=0111 showing A. Exactly one an bit SHALL be low outside reset.
REQ-024 an, seg and dp SHALL be registered. They SHALL reflect the index and the selected input value from the previous clock (1-clock latency), and SHALL change in the same clock so no digit shows another digit's value.
REQ-025 Hex encoding (seg, active-low gfedcba) SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-026 dp SHALL be 0 only when index=2 and mode_sel[1]=1 (separating operands from result). Otherwise dp SHALL be 1.
REQ-027 A mode advance SHALL NOT reset the scan counter or the digit index.

Reset
REQ-028 While reset_n=0 at a clock edge, the block SHALL load: mode_sel=00, mode_changed=0, an=1111, seg=1111111, dp=1, all counters 0, digit index 0, synchronizer and accepted level 0.
REQ-029 Reset asserted mid-debounce or mid-scan SHALL discard the partial count. No next_pulse or advance SHALL occur in the clock following release.
REQ-030 In the first clock after release, the block SHALL drive an=1110 with seg encoding D.

Verification (DEBOUNCE_CYCLES=4, SCAN_CYCLES=3, AUTO_CYCLES=20)
REQ-031 Reset, A..D=6,4,9,6 -> an sequence 1110,1101,1011,0111 with 3 clocks each; seg=0000010 on indices 0 and 3, 0010000 on index 1, 0011001 on index 2; dp=1 throughout.
REQ-032 btn_next high for 2 clocks, low, high 10 clocks -> exactly one mode_changed pulse; mode_sel 00->01.
REQ-033 Four clean presses -> mode_sel 01,10,11,00 with one mode_changed each; when mode_sel[1]=1, dp=0 only while an=1011.
REQ-034 auto_en=1, no press -> advance every 20 clocks. A press accepted at auto count 19 -> single advance, counter restarts at 0.
REQ-035 Reset asserted in mode 11 during index 2 -> next clock: mode_sel=00, an=1111, seg=1111111, dp=1.
REQ-036 Held button for 50 clocks then released -> one advance only; no advance on release.
